// File: rtl/hss_fixed_pkg.sv
// Fixed-point constants and helpers shared across the HSS pipeline.
// Q_FRAC/DATA_W/PROB_W formats, normalizer FSM states, clog2.
package hss_fixed_pkg;

  localparam int Q_FRAC = 10;
  localparam int DATA_W = 16;
  localparam int PROB_W = 11;
  localparam int MAG_W  = DATA_W - 1;

  // EMIT is not a separate state: it is the DIVIDE cycle
  // in which the divider reports done (or the sum is zero).
  typedef enum logic {
    COLLECT,
    DIVIDE
  } norm_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/exp_norm_if.sv
// Sample-in / probability-out bundle of the exp normalizer.
// in_data/in_valid/in_ready, out_data/out_valid/out_last/out_zero.
interface exp_norm_if;
  import hss_fixed_pkg::*;

  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [PROB_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     out_zero;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid,
    input  out_last, out_zero
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid,
    output out_last, out_zero
  );

endinterface

// File: rtl/udiv_restoring.sv
// Serial restoring divider, one quotient bit per cycle.
// start/busy/done handshake, dividend, divisor, quotient.
module udiv_restoring
  import hss_fixed_pkg::*;
#(
  parameter int DVD_W = 25,
  parameter int DVS_W = 17,
  parameter int Q_W   = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CNT_W = clog2(Q_W + 1);

  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [Q_W-1:0]   q;
  logic [CNT_W-1:0] cnt;
  logic [DVS_W:0]   trial;
  logic [DVS_W+1:0] diff;
  logic             ge;

  // q holds the unconsumed low dividend bits on its left
  // and collects quotient bits on its right.
  always_comb begin
    trial = {rem, q[Q_W-1]};
    diff  = {1'b0, trial} - {2'b00, dvs};
    ge    = ~diff[DVS_W+1];
  end

  // Only Q_W quotient bits are produced, so the caller
  // guarantees dividend >> Q_W is below the divisor.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rem  <= '0;
      dvs  <= '0;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= DVS_W'(dividend >> Q_W);
        q    <= dividend[Q_W-1:0];
        dvs  <= divisor;
        cnt  <= CNT_W'(Q_W);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= ge ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
        q   <= {q[Q_W-2:0], ge};
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = q;

endmodule

// File: rtl/exp_norm.sv
// Softmax normalizer: buffers N_ELEM 5.10 exp values, emits Q0.10 shares.
// CLK, RST (sync, active low), bus (exp_norm_if.slave).
module exp_norm
  import hss_fixed_pkg::*;
#(
  parameter int N_ELEM = 4
) (
  input logic       CLK,
  input logic       RST,
  exp_norm_if.slave bus
);

  localparam int IDX_W = clog2(N_ELEM);
  localparam int SUM_W = MAG_W + IDX_W;
  localparam int DVD_W = MAG_W + Q_FRAC;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  norm_state_e state, state_nxt;

  logic [MAG_W-1:0]  buf_q [N_ELEM];
  logic [SUM_W-1:0]  sum;
  logic [IDX_W-1:0]  wr_idx, rd_idx, ld_idx;
  logic [MAG_W-1:0]  mag;
  logic [PROB_W-1:0] quot;
  logic              accept, zero, emit, rd_last;
  logic              start, busy, done;

  // Truncated Taylor terms can dip below zero.
  assign mag     = bus.in_data[DATA_W-1] ? '0
                                         : bus.in_data[MAG_W-1:0];
  assign accept  = bus.in_valid && bus.in_ready;
  assign zero    = (sum == '0);
  assign rd_last = (rd_idx == LAST_IDX);
  assign emit    = RST && (state == DIVIDE) && (zero || done);

  // The emit cycle of element k also loads element k+1.
  assign ld_idx = done ? rd_idx + IDX_W'(1) : rd_idx;
  assign start  = (state == DIVIDE) && !zero && !busy &&
                  !(done && rd_last);

  always_ff @(posedge CLK) begin
    if (!RST) state <= COLLECT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: if (accept && wr_idx == LAST_IDX) state_nxt = DIVIDE;
      DIVIDE:  if (emit && rd_last) state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.out_zero  = 1'b0;
    unique case (state)
      COLLECT: bus.in_ready = RST;
      DIVIDE: begin
        bus.out_valid = emit;
        bus.out_data  = (emit && !zero) ? quot : '0;
        bus.out_last  = emit && rd_last;
        bus.out_zero  = emit && zero;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (accept) buf_q[wr_idx] <= mag;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sum    <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (accept) begin
        sum    <= sum + SUM_W'(mag);
        wr_idx <= (wr_idx == LAST_IDX) ? '0
                                       : wr_idx + IDX_W'(1);
      end
      if (emit) begin
        if (rd_last) begin
          sum    <= '0;
          rd_idx <= '0;
        end else begin
          rd_idx <= rd_idx + IDX_W'(1);
        end
      end
    end
  end

  udiv_restoring #(
    .DVD_W (DVD_W),
    .DVS_W (SUM_W),
    .Q_W   (PROB_W)
  ) u_div (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .dividend ({buf_q[ld_idx], {Q_FRAC{1'b0}}}),
    .divisor  (sum),
    .busy     (busy),
    .done     (done),
    .quotient (quot)
  );

endmodule

// File: tb/tb_exp_norm.sv
// Directed table-driven bench for exp_norm (N_ELEM=4).
// Drives exp_norm_if, checks values, pulse timing, reset abort.
module tb_exp_norm;

  logic CLK;
  logic RST;
  int   n_vec = 0;
  int   n_bad = 0;

  exp_norm_if bus ();

  exp_norm #(.N_ELEM(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0][15:0] din;
    logic [3:0][10:0] expv;
    logic             zero;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(
    input logic [15:0] d0, d1, d2, d3,
    input logic [10:0] e0, e1, e2, e3,
    input logic z
  );
    vec_t r;
    r.din[0] = d0; r.din[1] = d1;
    r.din[2] = d2; r.din[3] = d3;
    r.expv[0] = e0; r.expv[1] = e1;
    r.expv[2] = e2; r.expv[3] = e3;
    r.zero = z;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  task automatic run_frame(input vec_t v, input int id, input bit hold);
    int k;
    int cyc;
    int off;
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = v.din[i];
      bus.in_valid = 1'b1;
      chk($sformatf("v%0d_ready_in%0d", id, i), int'(bus.in_ready), 1);
      tick();
    end
    bus.in_valid = hold;
    bus.in_data  = 16'h7fff;
    chk($sformatf("v%0d_ready_busy", id), int'(bus.in_ready), 0);
    k   = 0;
    cyc = 1;
    while (k < 4 && cyc < 80) begin
      if (bus.out_valid) begin
        off = v.zero ? 1 + k : 13 + 12 * k;
        chk($sformatf("v%0d_data%0d", id, k),
            int'(bus.out_data), int'(v.expv[k]));
        chk($sformatf("v%0d_time%0d", id, k), cyc, off);
        chk($sformatf("v%0d_last%0d", id, k),
            int'(bus.out_last), (k == 3) ? 1 : 0);
        chk($sformatf("v%0d_zero%0d", id, k),
            int'(bus.out_zero), int'(v.zero));
        k++;
      end
      if (k < 4) begin
        tick();
        cyc++;
      end
    end
    if (k < 4) chk($sformatf("v%0d_pulse_count", id), k, 4);
    tick();
    chk($sformatf("v%0d_ready_after", id), int'(bus.in_ready), 1);
    chk($sformatf("v%0d_no_extra", id), int'(bus.out_valid), 0);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    vecs[0] = mk(16'h0400, 16'h0400, 16'h0400, 16'h0400,
                 11'h100, 11'h100, 11'h100, 11'h100, 1'b0);
    vecs[1] = mk(16'h0400, 16'h0C00, 16'h0000, 16'h0000,
                 11'h100, 11'h300, 11'h000, 11'h000, 1'b0);
    vecs[2] = mk(16'h0001, 16'h0001, 16'h0001, 16'h0000,
                 11'h155, 11'h155, 11'h155, 11'h000, 1'b0);
    vecs[3] = mk(16'hFC00, 16'h0800, 16'h8000, 16'h0800,
                 11'h000, 11'h200, 11'h000, 11'h200, 1'b0);
    vecs[4] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000,
                 11'h000, 11'h000, 11'h000, 11'h000, 1'b1);
    vecs[5] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                 11'h100, 11'h100, 11'h100, 11'h100, 1'b0);
    vecs[6] = mk(16'h0400, 16'h0000, 16'h0000, 16'h0000,
                 11'h400, 11'h000, 11'h000, 11'h000, 1'b0);
    vecs[7] = mk(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                 11'h000, 11'h000, 11'h000, 11'h000, 1'b1);

    RST          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick();
    tick();
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_last", int'(bus.out_last), 0);
    chk("rst_zero", int'(bus.out_zero), 0);
    RST = 1'b1;
    #1;
    chk("post_rst_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], i, 1'b0);

    // Samples offered during DIVIDE must be dropped.
    run_frame(vecs[1], 10, 1'b1);
    run_frame(vecs[0], 11, 1'b0);

    // Abort a frame mid-divide with a one-cycle reset.
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = 16'h0400;
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    RST = 1'b0;
    #1;
    chk("abort_ready_in_rst", int'(bus.in_ready), 0);
    tick();
    RST = 1'b1;
    #1;
    chk("abort_ready_next", int'(bus.in_ready), 1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid) cnt++;
      tick();
    end
    chk("abort_no_output", cnt, 0);
    run_frame(vecs[0], 12, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/exp_norm.md
# exp_norm

Downstream stage of the Taylor-series exponential unit in the HSS pipeline. It collects a frame of `N_ELEM` exponential values in 5.10 fixed point, one per HSMM state, and accumulates their sum. It then emits each value divided by the sum as a normalized probability in Q0.10. This gives the softmax step that turns per-state exp scores into state probabilities for the segmentation logic.

## Interface
- `N_ELEM`, default 4: elements per frame (HSS states); legal range 2..16.
- `CLK`  in  1  : the single clock; all logic on its rising edge.
- `RST`  in  1  : synchronous, active-low reset; sampled on the `CLK` rising edge.
- `in_data`  in  16 signed  : exp result, 5.10 fixed point.
- `in_valid`  in  1  : `in_data` is valid this cycle. Driven by the upstream write enable.
- `in_ready`  out  1  : block accepts a sample this cycle.
- `out_data`  out  11 unsigned  : normalized value, Q0.10, range 0..1024.
- `out_valid`  out  1  : one-cycle pulse; `out_data` is valid.
- `out_last`  out  1  : high with `out_valid` on the last element of a frame.
- `out_zero`  out  1  : high with `out_valid` when the frame sum was 0.

## Operation
- **States:**
  - COLLECT: `in_ready`=1. A sample is accepted when `in_valid`=1 and `in_ready`=1.
  - DIVIDE: `in_ready`=0. Serial divide for the current element.
  - EMIT: internal; one cycle, overlaps the next element's load (see Timing).
- **Accepting a sample:**
  - Negative `in_data` is clamped to 0, because truncated Taylor terms can go negative.
  - The clamped value (15 bit unsigned) is stored in an `N_ELEM`-entry buffer at index `wr_idx`.
  - The value is added to `sum`. `sum` is 15+ceil(log2 `N_ELEM`) bits wide, so it cannot overflow.
- **Frame end:** when the `N_ELEM`-th sample is accepted, go to DIVIDE with `rd_idx`=0.
- **Division:** quotient = (buf[`rd_idx`] << 10) / `sum`, truncated toward zero.
  - Because buf ≤ `sum`, the quotient is ≤ 1024 and fits 11 bits.
  - Restoring divider, one quotient bit per cycle, 11 iterations.
- **Zero sum:** when `sum`==0, no division runs. Each element emits `out_data`=0 with `out_zero`=1 at one element per cycle.
- **After the last element:**
  - `sum`, `wr_idx` and `rd_idx` clear, and the state returns to COLLECT.
  - Buffer contents are don't-care.
- **No backpressure on output:** the consumer must take every `out_valid` pulse.
- **Reset values:** `in_ready`=0 during reset and 1 on the first cycle after reset. `out_data`=0, `out_valid`=0, `out_last`=0, `out_zero`=0. State COLLECT, `sum`=0, indices 0.

## Timing
- Let T be the cycle in which the last sample of a frame is accepted. `in_ready` is 0 from T+1 on.
- **Per element k:**
  - Divider load at T+1+12k.
  - 11 iterate cycles.
  - `out_valid` at T+13+12k; element k+1 loads in the same cycle.
- Last output is at T+13+12(`N_ELEM`-1). `in_ready` returns to 1 on the next cycle.
- **Zero-sum frame:** `out_valid` at T+1+k; `in_ready` returns to 1 at T+1+`N_ELEM`.
- **Samples while busy:** samples offered while `in_ready`=0 are ignored, not queued.
  - The upstream unit's enable stays high, so the system wrapper is responsible for frame alignment.
- **Reset mid-frame or mid-divide:** RST low for one cycle aborts the frame with no partial output. The next cycle is COLLECT with an empty frame.
- **Throughput:** `N_ELEM`+12·`N_ELEM`+1 cycles per frame (53 for `N_ELEM`=4).

## Structure
- **Shared package `hss_fixed_pkg`:**
  - `Q_FRAC`=10, `DATA_W`=16, `PROB_W`=11.
  - Helper `clog2` used for `sum` and index widths.
  - The package is reused by the exp unit and the downstream HSMM logic.
- **Sub-module `udiv_restoring`:**
  - Parameters: dividend width, divisor width, quotient bits.
  - Ports: `start`/`busy`/`done` handshake; `done` is a one-cycle pulse.
  - `exp_norm` holds the FSM, buffer and accumulator.

## Test plan
- Frame 0x0400 ×4 (`N_ELEM`=4) -> `out_data` 0x100 on all four pulses 12 cycles apart. `out_last` on the 4th; first pulse at T+13.
- Frame 0x0400, 0x0C00, 0, 0 -> 0x100, 0x300, 0x000, 0x000.
- Frame 0x0001, 0x0001, 0x0001, 0x0000 -> 0x155, 0x155, 0x155, 0x000 (truncation check).
- Frame 0xFC00, 0x0800, 0x8000, 0x0800 -> negatives clamped, giving 0x000, 0x200, 0x000, 0x200.
- Frame all 0 -> four consecutive-cycle pulses of 0 with `out_zero`=1, then `in_ready`=1 at T+5.
- Reset and idle behaviour:
  - RST low at T+6 of a 0x0400 frame -> no further `out_valid`, `in_ready`=1 next cycle.
  - A following 0x0400 ×4 frame yields 0x100 ×4.
  - `in_valid` held high during DIVIDE -> those samples are dropped and the sum is unaffected.
